// File: rtl/bwt_backward_search.sv
// Exact-match BWT backward-search controller driving a dual-read-port OCC table.
// Define BWT_PERF_CNT_EN to add the rd_count output (saturating count of read cycles).
`timescale 1ns/1ps
module bwt_backward_search #(
  parameter int WIDTHS     = 1920,
  parameter int CHUNK      = 896,
  parameter int ADDR_WIDTH = 5,
  parameter int IDX_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [IDX_WIDTH-1:0]   ref_len,
  input  logic [IDX_WIDTH-1:0]   dollar_pos,
  input  logic [4*IDX_WIDTH-1:0] c_table,
  input  logic                   char_valid,
  input  logic [1:0]             char_in,
  input  logic                   char_last,
  output logic                   char_ready,
  output logic                   rEn,
  output logic [ADDR_WIDTH-1:0]  rAddr0,
  output logic [ADDR_WIDTH-1:0]  rAddr1,
  input  logic [WIDTHS-1:0]      rData0,
  input  logic [WIDTHS-1:0]      rData1,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   found,
  output logic [IDX_WIDTH-1:0]   top,
  output logic [IDX_WIDTH-1:0]   bot,
`ifdef BWT_PERF_CNT_EN
  output logic [15:0]            rd_count,
`endif
  output logic [1:0]             dbgState
);

  // Handshakes: a character transfers on a cycle with char_valid && char_ready,
  // a result transfers on a cycle with res_valid && res_ready; res_valid and the
  // result fields hold steady until that transfer, and char_ready never waits on char_valid.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    CALC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, stateNext;

  logic                 miss;
  logic                 lastReg;
  logic [1:0]           cReg;
  logic [IDX_WIDTH-1:0] offTop, offBot;
  logic                 charAccept;

  logic [IDX_WIDTH-1:0] cBase;
  logic [IDX_WIDTH-1:0] topOcc, botOcc;
  logic                 sentTop, sentBot;
  logic [IDX_WIDTH-1:0] newTop, newBot;

  // occ(c, row base + off): checkpoint count plus matching codes in positions < off.
  function automatic logic [IDX_WIDTH-1:0] occCount(input logic [WIDTHS-1:0] row,
                                                    input logic [1:0] c,
                                                    input logic [IDX_WIDTH-1:0] off);
    logic [IDX_WIDTH-1:0] n;
    n = row[c*IDX_WIDTH +: IDX_WIDTH];
    for (int k = 0; k < CHUNK; k++) begin
      if ((IDX_WIDTH'(unsigned'(k)) < off) && (row[4*IDX_WIDTH + 2*k +: 2] == c))
        n = n + IDX_WIDTH'(1);
    end
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    char_ready = 1'b0;
    charAccept = 1'b0;
    rEn        = 1'b0;
    rAddr0     = '0;
    rAddr1     = '0;
    res_valid  = 1'b0;
    found      = 1'b0;
    case (state)
      IDLE: begin
        if (start) stateNext = READY;
      end
      READY: begin
        char_ready = 1'b1;
        if (char_valid) begin
          charAccept = 1'b1;
          if (!miss) begin
            rEn       = !rst;
            rAddr0    = ADDR_WIDTH'(top / IDX_WIDTH'(CHUNK));
            rAddr1    = ADDR_WIDTH'(bot / IDX_WIDTH'(CHUNK));
            stateNext = CALC;
          end else if (char_last) begin
            stateNext = DONE;
          end
        end
      end
      CALC: begin
        stateNext = lastReg ? DONE : READY;
      end
      DONE: begin
        res_valid = 1'b1;
        found     = !miss;
        if (res_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // The row base is i - (i % CHUNK); top/bot are unchanged until the end of CALC.
  always_comb begin
    cBase   = c_table[cReg*IDX_WIDTH +: IDX_WIDTH];
    topOcc  = occCount(rData0, cReg, offTop);
    botOcc  = occCount(rData1, cReg, offBot);
    sentTop = (cReg == 2'd0) && ((top - offTop) <= dollar_pos) && (dollar_pos < top);
    sentBot = (cReg == 2'd0) && ((bot - offBot) <= dollar_pos) && (dollar_pos < bot);
    newTop  = cBase + topOcc - IDX_WIDTH'(sentTop);
    newBot  = cBase + botOcc - IDX_WIDTH'(sentBot);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top     <= '0;
      bot     <= '0;
      miss    <= 1'b0;
      cReg    <= 2'd0;
      lastReg <= 1'b0;
      offTop  <= '0;
      offBot  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            top  <= '0;
            bot  <= ref_len;
            miss <= 1'b0;
          end
        end
        READY: begin
          if (charAccept && !miss) begin
            cReg    <= char_in;
            lastReg <= char_last;
            offTop  <= top % IDX_WIDTH'(CHUNK);
            offBot  <= bot % IDX_WIDTH'(CHUNK);
          end
        end
        CALC: begin
          top <= newTop;
          bot <= newBot;
          if (newTop >= newBot) miss <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BWT_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                rd_count <= '0;
    else if (rEn && (rd_count != 16'hFFFF)) rd_count <= rd_count + 16'd1;
  end
`endif

  assign dbgState = state;

endmodule

// File: tb/tb_bwt_backward_search.sv
// Scoreboard bench for bwt_backward_search: prefix-count reference model, random and directed searches.
`timescale 1ns/1ps
module tb_bwt_backward_search;
  localparam int W     = 1920;
  localparam int CH    = 896;
  localparam int NCODE = 4 * CH;

  logic         clk, rst, start;
  logic [31:0]  ref_len, dollar_pos;
  logic [127:0] c_table;
  logic         char_valid, char_last, char_ready, rEn;
  logic [1:0]   char_in;
  logic [4:0]   rAddr0, rAddr1;
  logic [W-1:0] rData0, rData1;
  logic         res_valid, res_ready, found;
  logic [31:0]  top, bot;
  logic [1:0]   dbgState;
`ifdef BWT_PERF_CNT_EN
  logic [15:0]  rd_count;
`endif

  logic [1:0]   codes [0:NCODE-1];
  logic [31:0]  ctab [4];
  logic [W-1:0] mem [0:31];
  logic [1:0]   pat [$];
  logic [64:0]  exp_q [$];
  int           acc_cyc [$];

  int n_cmp = 0, n_fail = 0, cyc = 0, ren_cnt = 0, rv_cyc = 0, snap;
  logic [4:0]  ra0_last, ra1_last;
  logic        rv_prev = 1'b0, hold = 1'b0, h_found, last_found;
  logic [31:0] h_top, h_bot, last_top, last_bot;
  logic [64:0] mon_e;
  logic        rr_force, rr_val;

  assign c_table = {ctab[3], ctab[2], ctab[1], ctab[0]};

  bwt_backward_search dut (
    .clk(clk), .rst(rst), .start(start), .ref_len(ref_len), .dollar_pos(dollar_pos),
    .c_table(c_table), .char_valid(char_valid), .char_in(char_in), .char_last(char_last),
    .char_ready(char_ready), .rEn(rEn), .rAddr0(rAddr0), .rAddr1(rAddr1),
    .rData0(rData0), .rData1(rData1), .res_valid(res_valid), .res_ready(res_ready),
    .found(found), .top(top), .bot(bot),
`ifdef BWT_PERF_CNT_EN
    .rd_count(rd_count),
`endif
    .dbgState(dbgState)
  );

  // clock / reset-free infrastructure
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  // OCC SRAM: one-cycle read latency
  always @(posedge clk) begin
    if (rEn) begin
      rData0 <= mem[rAddr0];
      rData1 <= mem[rAddr1];
    end
  end

  initial begin
    rr_force = 1'b0;
    rr_val   = 1'b0;
    res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      res_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  // reference model: occ from a direct prefix scan of the stored codes, $ excluded from A
  function automatic logic [31:0] model_occ(input logic [1:0] c, input logic [31:0] i);
    logic [31:0] n = 0;
    for (int j = 0; j < NCODE && j < i; j++)
      if (codes[j] == c) n++;
    if (c == 2'd0 && dollar_pos < i) n--;
    return n;
  endfunction

  function automatic logic [64:0] model_search();
    logic [31:0] t = 0, b = ref_len, nt, nb;
    logic miss = 1'b0;
    for (int k = 0; k < pat.size(); k++) begin
      if (!miss) begin
        nt = ctab[pat[k]] + model_occ(pat[k], t);
        nb = ctab[pat[k]] + model_occ(pat[k], b);
        t = nt;
        b = nb;
        if (nt >= nb) miss = 1'b1;
      end
    end
    return {!miss, t, b};
  endfunction

  task automatic build_mem();
    for (int r = 0; r < 32; r++) mem[r] = '0;
    for (int r = 0; r < 4; r++) begin
      logic [31:0] ck [4];
      for (int c = 0; c < 4; c++) ck[c] = 0;
      for (int j = 0; j < r * CH; j++) ck[codes[j]]++;
      if (dollar_pos < r * CH) ck[0]--;
      for (int c = 0; c < 4; c++) mem[r][32*c +: 32] = ck[c];
      for (int k = 0; k < CH; k++) mem[r][128 + 2*k +: 2] = codes[r*CH + k];
    end
  endtask

  task automatic setup_t1();
    for (int j = 0; j < NCODE; j++) codes[j] = (j < 2 * CH) ? 2'd1 : 2'd0;
    ref_len = 900; dollar_pos = 899;
    ctab[0] = 1; ctab[1] = 1; ctab[2] = 901; ctab[3] = 901;
    build_mem();
  endtask

  task automatic setup_t2();
    for (int j = 0; j < NCODE; j++) codes[j] = 2'd0;
    ref_len = 10; dollar_pos = 3;
    ctab[0] = 1; ctab[1] = 10; ctab[2] = 10; ctab[3] = 10;
    build_mem();
  endtask

  task automatic setup_rand(input int n);
    int cnt [4];
    for (int j = 0; j < NCODE; j++) codes[j] = 2'($urandom_range(0, 3));
    ref_len = n;
    dollar_pos = $urandom_range(0, n - 1);
    codes[dollar_pos] = 2'd0;
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int j = 0; j < n; j++) if (j != dollar_pos) cnt[codes[j]]++;
    ctab[0] = 1;
    ctab[1] = 1 + cnt[0];
    ctab[2] = ctab[1] + cnt[1];
    ctab[3] = ctab[2] + cnt[2];
    build_mem();
  endtask

  // driver: start plus back-to-back characters; expected result pushed on issue
  task automatic run_search(input bit push_exp);
    int guard = 0;
    logic acc;
    @(posedge clk); #1;
    while (dbgState != 2'd0 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 300) fail_now("idle_wait");
    if (push_exp) exp_q.push_back(model_search());
    acc_cyc.delete();
    start = 1'b1;
    for (int k = 0; k < pat.size(); k++) begin
      char_valid = 1'b1;
      char_in    = pat[k];
      char_last  = (k == pat.size() - 1);
      guard = 0;
      do begin
        @(negedge clk);
        acc = char_ready;
        if (acc) acc_cyc.push_back(cyc);
        @(posedge clk); #1;
        start = 1'b0;
        guard++;
      end while (!acc && guard < 100);
      if (!acc) fail_now("char_accept");
    end
    char_valid = 1'b0;
    char_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(exp_q.size() == 0 && dbgState == 2'd0 && !res_valid) && guard < 400);
    if (guard >= 400) fail_now(name);
  endtask

  // read-port monitor
  always @(negedge clk) begin
    if (rEn) begin
      ren_cnt++;
      ra0_last = rAddr0;
      ra1_last = rAddr1;
    end
    if (res_valid && !rv_prev) rv_cyc = cyc;
    rv_prev = res_valid;
  end

  // result monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (res_valid) begin
        check("done_char_ready", char_ready, 0);
        if (hold) begin
          check("hold_found", found, h_found);
          check("hold_top", top, h_top);
          check("hold_bot", bot, h_bot);
        end
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("res_unexpected");
        end else begin
          mon_e = exp_q.pop_front();
          check("res_found", found, mon_e[64]);
          check("res_top", top, mon_e[63:32]);
          check("res_bot", bot, mon_e[31:0]);
        end
        last_found = found;
        last_top   = top;
        last_bot   = bot;
        hold = 1'b0;
      end else if (res_valid) begin
        hold = 1'b1;
        h_found = found;
        h_top = top;
        h_bot = bot;
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_char_ready"}, char_ready, 0);
    check({tag, "_rEn"}, rEn, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_found"}, found, 0);
    check({tag, "_rAddr0"}, rAddr0, 0);
    check({tag, "_rAddr1"}, rAddr1, 0);
    check({tag, "_top"}, top, 0);
    check({tag, "_bot"}, bot, 0);
    check({tag, "_state"}, dbgState, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; char_valid = 1'b0; char_in = 2'd0; char_last = 1'b0;
    setup_t1();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // arithmetic and latency
    pat = '{2'd1};
    snap = ren_cnt;
    run_search(1);
    wait_idle("t1_done");
    check("t1_ren_cycles", ren_cnt - snap, 1);
    check("t1_rAddr0", ra0_last, 0);
    check("t1_rAddr1", ra1_last, 1);
    check("t1_latency", rv_cyc - acc_cyc[0], 2);
    check("t1_top", last_top, 1);
    check("t1_bot", last_bot, 901);
    check("t1_found", last_found, 1);

    // sentinel correction
    setup_t2();
    pat = '{2'd0};
    run_search(1);
    wait_idle("t2_done");
    check("t2_top", last_top, 1);
    check("t2_bot", last_bot, 10);
    check("t2_found", last_found, 1);

    // miss and drain
    pat = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd0};
    snap = ren_cnt;
    run_search(1);
    wait_idle("miss_done");
    check("miss_ren_cycles", ren_cnt - snap, 1);
    for (int k = 2; k < 5; k++) check("miss_drain_gap", acc_cyc[k] - acc_cyc[k-1], 1);
    check("miss_found", last_found, 0);
    check("miss_top", last_top, 10);
    check("miss_bot", last_bot, 10);

    // result backpressure, start/char ignored while DONE
    rr_force = 1'b1; rr_val = 1'b0;
    pat = '{2'd0};
    run_search(1);
    begin
      int guard = 0;
      do begin @(negedge clk); guard++; end while (!res_valid && guard < 20);
      if (!res_valid) fail_now("bp_res_valid");
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      start = 1'b1; char_valid = 1'b1; char_in = 2'd2; char_last = 1'b1;
      @(negedge clk);
      check("bp_res_valid", res_valid, 1);
      check("bp_top", top, 1);
      check("bp_bot", bot, 10);
      check("bp_found", found, 1);
      check("bp_char_ready", char_ready, 0);
    end
    @(posedge clk); #1;
    start = 1'b0; char_valid = 1'b0; char_last = 1'b0; rr_val = 1'b1;
    @(posedge clk); #1;
    rr_force = 1'b0;
    @(negedge clk);
    check("bp_release_valid", res_valid, 0);
    check("bp_release_state", dbgState, 0);

    // reset in CALC, then the same pattern from clean
    setup_t1();
    wait_idle("rst_pre");
    @(posedge clk); #1;
    start = 1'b1; char_valid = 1'b1; char_in = 2'd1; char_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("rst_ready_before", char_ready, 1);
    @(posedge clk); #1;
    char_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_no_result", exp_q.size(), 0);
    pat = '{2'd1, 2'd1};
    run_search(1);
    wait_idle("rst_rerun");
    check("rerun_top", last_top, 2);
    check("rerun_bot", last_bot, 902);

    // three 4-character matching searches after a reset
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    snap = ren_cnt;
    pat = '{2'd1, 2'd1, 2'd1, 2'd1};
    repeat (3) run_search(1);
    wait_idle("perf_done");
    check("perf_ren_cycles", ren_cnt - snap, 12);
`ifdef BWT_PERF_CNT_EN
    check("perf_rd_count", rd_count, 12);
`endif

    // randomized datasets and patterns, including N on a row boundary
    for (int ds = 0; ds < 6; ds++) begin
      wait_idle("rand_setup");
      setup_rand(ds == 0 ? 2 * CH : $urandom_range(10, 3 * CH));
      for (int s = 0; s < 6; s++) begin
        int len;
        len = $urandom_range(1, 6);
        pat.delete();
        for (int k = 0; k < len; k++) pat.push_back(2'($urandom_range(0, 3)));
        run_search(1);
      end
    end
    wait_idle("rand_done");

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bwt_backward_search.md
Name: bwt_backward_search

Overview:
- Exact-match backward-search controller for the BWT aligner.
- Consumes one pattern, last character first, and drives the dual-read-port OCC table SRAM: port 0 for the top bound, port 1 for the bottom bound.
- Consumes the two returned rows, computes occ(c,i), and updates the suffix-array interval [top, bot).
- Reports found/not-found and the final interval to the downstream SA-lookup stage.

Parameters:
- WIDTHS, 1920, OCC row width: bits [127:0] hold four 32-bit checkpoint counts (A at [31:0], C at [63:32], G at [95:64], T at [127:96]); bits [1919:128] hold 896 2-bit BWT codes, code k at [128+2k+1:128+2k].
- CHUNK, 896, BWT codes per row.
- ADDR_WIDTH, 5, OCC row address width.
- IDX_WIDTH, 32, width of top, bot and counts.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse in IDLE: top<=0, bot<=ref_len
- ref_len  in  IDX_WIDTH  BWT length N, including $
- dollar_pos  in  IDX_WIDTH  BWT index of $ (stored as code 0)
- c_table  in  4*IDX_WIDTH  C[A..T], same packing as the checkpoint counts
- char_valid  in  1  pattern character valid
- char_in  in  2  pattern character: A=0, C=1, G=2, T=3
- char_last  in  1  final (leftmost) pattern character
- char_ready  out  1  character accepted when valid&ready
- rEn  out  1  OCC SRAM read enable
- rAddr0  out  ADDR_WIDTH  row of top
- rAddr1  out  ADDR_WIDTH  row of bot
- rData0  in  WIDTHS  OCC row for top, valid the cycle after rEn
- rData1  in  WIDTHS  OCC row for bot, valid the cycle after rEn
- res_valid  out  1  result valid, held until res_ready
- res_ready  in  1  downstream accept
- found  out  1  1 = interval non-empty after the last character
- top  out  IDX_WIDTH  final interval start
- bot  out  IDX_WIDTH  final interval end (exclusive)

Behaviour:
- Reset values: state=IDLE; char_ready, rEn, res_valid, found = 0; rAddr0, rAddr1, top, bot = 0; miss=0.
- IDLE:
  - start -> READY; top=0, bot=ref_len, miss=0.
  - Characters arriving in IDLE are not accepted (char_ready=0).
- READY:
  - char_ready=1.
  - On accept with miss=0: rEn=1 in the same cycle; rAddr0=top/CHUNK, rAddr1=bot/CHUNK; latch c, last, offsets top%CHUNK and bot%CHUNK; next state CALC.
  - On accept with miss=1: no read (rEn=0); stay in READY, or go to DONE if last.
- CALC (one cycle, char_ready=0):
  - occ(c,i) = cnt_c(row) + number of codes equal to c at chunk positions < offset. Offset 0 gives the checkpoint count only.
  - Sentinel correction: if c==A and row*CHUNK <= dollar_pos < i, subtract 1.
  - Register top' = C[c] + occ(c,top) and bot' = C[c] + occ(c,bot).
  - If top' >= bot', set miss=1.
  - Next state: DONE if last, else READY.
- Throughput: 2 cycles per character while matching; 1 cycle per character after a miss.
- Miss handling:
  - top and bot freeze at the values that collapsed.
  - Remaining characters are drained through char_last so the upstream pointer stays aligned.
- DONE:
  - res_valid=1; found = !miss.
  - On res_ready -> IDLE with res_valid=0.
  - start is ignored in every state except IDLE.
- Boundaries:
  - i == N is a legal index; the row N/CHUNK must exist in the table.
  - Arithmetic is modulo 2^IDX_WIDTH with no saturation.
  - char_last on the first character gives a single-character search.
- Reset mid-operation:
  - rEn deasserts and results are discarded in the reset cycle.
  - Any rData arriving afterwards is ignored.

Optional Feature:
- Macro: BWT_PERF_CNT_EN.
- Defined:
  - Adds output port rd_count, 16 bits.
  - Counts cycles with rEn=1 since reset, saturating at 16'hFFFF.
  - Cleared by rst only; start does not clear it.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Arithmetic and latency:
  - Setup: row0 checkpoints 0 with all codes C; row1 checkpoint C=896 with all codes C; ref_len=900, C[C]=1, dollar_pos=899.
  - Stimulus: start, then char C with last.
  - Required: rEn for 1 cycle with rAddr0=0, rAddr1=1; res_valid 2 cycles after accept with top=1, bot=901, found=1.
- Sentinel correction:
  - Setup: row0 all code A, checkpoints 0; ref_len=10, dollar_pos=3, C[A]=1.
  - Stimulus: char A with last.
  - Required: top=1, bot=1+10-1=10.
- Miss and drain:
  - Stimulus: first character collapses the interval, pattern of 5 characters.
  - Required: rEn pulses exactly once; remaining 4 characters accepted in 4 consecutive cycles; found=0 with top/bot frozen.
- Handshake backpressure:
  - Stimulus: hold res_ready=0 for 10 cycles in DONE.
  - Required: res_valid and outputs stable and char_ready=0 throughout; res_ready=1 -> IDLE next cycle.
- Reset mid-operation:
  - Stimulus: rst asserted in CALC.
  - Required: next cycle all outputs at reset values; a new start with the same pattern gives the same result as a clean run.
- BWT_PERF_CNT_EN:
  - Stimulus: three 4-character matching searches.
  - Required: rd_count = 12.
